// File: rtl/hex_display.sv
//==============================================================================
// hex_display : saturating 0-255 BCD score counter with seven-segment outputs
// Build option: HEX_DISPLAY_LEADING_ZERO_BLANK_EN blanks leading-zero digits
// Revision    : 1.0
//==============================================================================
`default_nettype none

module hex_seg (
   input  logic [3:0] value,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h7F;
      case (value)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end
endmodule

module hex_display (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic [7:0] count,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2
);
   localparam logic [7:0] C_MAX = 8'd255;

   logic [3:0] r_ones;
   logic [3:0] r_tens;
   logic [3:0] r_hundreds;
   logic [7:0] r_count;
   logic [3:0] w_digit [3];
   logic [6:0] w_seg   [3];

   // BCD digits and binary count advance together so they never disagree
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         r_ones     <= 4'd0;
         r_tens     <= 4'd0;
         r_hundreds <= 4'd0;
         r_count    <= 8'd0;
      end else if (inc && (r_count != C_MAX)) begin
         r_count <= r_count + 8'd1;
         if (r_ones == 4'd9) begin
            r_ones <= 4'd0;
            if (r_tens == 4'd9) begin
               r_tens     <= 4'd0;
               r_hundreds <= r_hundreds + 4'd1;
            end else begin
               r_tens <= r_tens + 4'd1;
            end
         end else begin
            r_ones <= r_ones + 4'd1;
         end
      end
   end

   assign ones     = r_ones;
   assign tens     = r_tens;
   assign hundreds = r_hundreds;
   assign count    = r_count;

   assign w_digit[0] = r_ones;
   assign w_digit[1] = r_tens;
   assign w_digit[2] = r_hundreds;

   generate
      for (genvar i = 0; i < 3; i++) begin : g_dec
         hex_seg u_seg (
            .value (w_digit[i]),
            .seg   (w_seg[i])
         );
      end
   endgenerate

   assign hex0 = w_seg[0];
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
   assign hex2 = (r_hundreds == 4'd0) ? 7'h7F : w_seg[2];
   assign hex1 = ((r_hundreds == 4'd0) && (r_tens == 4'd0)) ? 7'h7F : w_seg[1];
`else
   assign hex2 = w_seg[2];
   assign hex1 = w_seg[1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_hex_display.sv
//==============================================================================
// tb_hex_display : directed self-checking bench for hex_display and hex_seg
// Revision       : 1.0
//==============================================================================
`default_nettype none

module tb_hex_display;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       inc = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] ones, tens, hundreds;
   logic [7:0] count;
   logic [6:0] hex0, hex1, hex2;
   logic [3:0] dec_in = 4'h0;
   logic [6:0] dec_out;

   int n_checks = 0;
   int n_fail   = 0;
   int v        = 0;

   localparam logic [6:0] SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   hex_display dut (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc),
      .clr      (clr),
      .ones     (ones),
      .tens     (tens),
      .hundreds (hundreds),
      .count    (count),
      .hex0     (hex0),
      .hex1     (hex1),
      .hex2     (hex2)
   );

   hex_seg u_dec (
      .value (dec_in),
      .seg   (dec_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected digits/segments are derived arithmetically from the integer score
   task automatic chk_val(input string tag, input int val);
      int h, t, o;
      logic [6:0] e1, e2;
      h  = val / 100;
      t  = (val / 10) % 10;
      o  = val % 10;
      e1 = SEG[t];
      e2 = SEG[h];
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
      if (h == 0) e2 = 7'h7F;
      if (h == 0 && t == 0) e1 = 7'h7F;
`endif
      chk({tag, ".digits"}, {20'd0, hundreds, tens, ones}, {20'd0, h[3:0], t[3:0], o[3:0]});
      chk({tag, ".count"}, {24'd0, count}, val);
      chk({tag, ".hex0"}, {25'd0, hex0}, {25'd0, SEG[o]});
      chk({tag, ".hex1"}, {25'd0, hex1}, {25'd0, e1});
      chk({tag, ".hex2"}, {25'd0, hex2}, {25'd0, e2});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held with inc high
      rst = 1'b0; inc = 1'b1; clr = 1'b0;
      step(); step();
      v = 0;
      chk_val("reset", v);
      chk("reset.hex0_lit", {25'd0, hex0}, 32'h40);
      rst = 1'b1;

      // count to 4, then hold with inc low
      for (int i = 0; i < 4; i++) begin
         step(); v++;
         chk_val("inc_to_4", v);
      end
      inc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_val("hold_4", v);
      end
      chk("hold_4.hex0", {25'd0, hex0}, 32'h19);

      // carries through 10 and 100
      inc = 1'b1;
      for (int i = 0; i < 96; i++) begin
         step(); v++;
         chk_val("carry", v);
      end
      chk("at100.digits", {20'd0, hundreds, tens, ones}, 32'h100);
      chk("at100.hex0", {25'd0, hex0}, 32'h40);
      chk("at100.hex2", {25'd0, hex2}, 32'h79);

      // saturation from zero
      inc = 1'b0; clr = 1'b1;
      step(); v = 0;
      chk_val("clr", v);
      clr = 1'b0; inc = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (v < 255) v++;
         chk_val("sat", v);
      end
      chk("sat.digits", {20'd0, hundreds, tens, ones}, 32'h255);
      chk("sat.hex2", {25'd0, hex2}, 32'h24);
      chk("sat.hex1", {25'd0, hex1}, 32'h12);
      chk("sat.hex0", {25'd0, hex0}, 32'h12);

      // clr wins over inc
      clr = 1'b1; inc = 1'b0;
      step(); v = 0;
      clr = 1'b0; inc = 1'b1;
      for (int i = 0; i < 37; i++) begin
         step(); v++;
      end
      chk_val("at37", v);
      clr = 1'b1; inc = 1'b1;
      step(); v = 0;
      chk_val("clr_inc", v);
      clr = 1'b0;
      for (int i = 0; i < 24; i++) begin
         step(); v++;
      end
      chk_val("at24", v);
      clr = 1'b1; inc = 1'b0;
      step(); v = 0;
      chk_val("clr24", v);
      clr = 1'b0; inc = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(); v++;
      end
      chk_val("after_clr20", v);

      // reset mid-count
      for (int i = 0; i < 130; i++) begin
         step(); v++;
      end
      chk_val("at150", v);
      rst = 1'b0;
      step(); v = 0;
      chk_val("mid_reset", v);
      rst = 1'b1;
      step(); v = 1;
      chk_val("resume", v);
      step(); v = 2;
      chk_val("resume2", v);
      inc = 1'b0;

      // standalone decoder sweep
      for (int i = 0; i < 16; i++) begin
         dec_in = i[3:0];
         #1;
         chk($sformatf("dec_%0h", i), {25'd0, dec_out}, {25'd0, SEG[i]});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
